sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: SRAM data width.
REQ-003 SHALL have port wb_clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a_req / b_req  input  1  access request from requester A / B.
REQ-006 SHALL have ports a_we / b_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports a_addr / b_addr  input  ADDR_W  access address.
REQ-008 SHALL have ports a_wdata / b_wdata  input  DATA_W  write data.
REQ-009 SHALL have ports a_gnt / b_gnt  output  1  grant; a request is accepted at an edge where req and gnt are both high.
REQ-010 SHALL have ports a_rvalid / b_rvalid  output  1  read data valid pulse.
REQ-011 SHALL have ports a_rdata / b_rdata  output  DATA_W  read data.
REQ-012 SHALL have port prio_mode  input  1  0 = round-robin, 1 = fixed priority to A.
REQ-013 SHALL have port clr_start  input  1  start a full-memory clear sweep.
REQ-014 SHALL have port busy  output  1  clear sweep in progress.
REQ-015 SHALL have port sram_addr  output  ADDR_W  registered SRAM address.
REQ-016 SHALL have port sram_in  output  DATA_W  registered SRAM write data.
REQ-017 SHALL have port sram_out  input  DATA_W  SRAM read data, valid after the edge following the access edge.
REQ-018 SHALL have port sram_gwe  output  1  registered write enable, active-low.
REQ-019 SHALL have port sram_cen  output  1  registered chip enable, active-low.

Function
REQ-020 SHALL implement states ARB and CLEAR; grants are issued only in ARB.
REQ-021 Grants SHALL be combinational from req, state, prio_mode and the last-grant pointer; at most one gnt high per cycle; gnt never high without its req.
REQ-022 Round-robin: when both request, the requester not granted last SHALL win; when one requests, it SHALL win.
REQ-023 Fixed mode: A SHALL win whenever a_req is high.
REQ-024 The last-grant pointer SHALL update only on acceptance, in both modes.
REQ-025 On acceptance, the next edge SHALL load sram_addr, sram_in, sram_cen=0 and sram_gwe=~we; in cycles with no acceptance, sram_cen and sram_gwe SHALL be 1.
REQ-026 One acceptance per cycle SHALL be sustainable back-to-back with no bubbles.
REQ-027 For a read accepted at edge E0, rdata SHALL be registered from sram_out at E2, and rvalid SHALL be high for exactly the one cycle following E2, on the accepting requester only.
REQ-028 Writes SHALL produce no rvalid; rdata SHALL hold its last value between reads.
REQ-029 clr_start high in ARB SHALL take priority over any req that cycle (no gnt) and enter CLEAR at the next edge.
REQ-030 In CLEAR: busy=1; writes of 0 SHALL be issued to addresses 0 .. 2^ADDR_W-1, one per cycle, ascending; the state SHALL return to ARB at the edge that issues the last address; busy=0 from then on.
REQ-031 clr_start SHALL be ignored while in CLEAR.
REQ-032 Reads accepted before CLEAR entry SHALL still complete with rvalid.

Reset
REQ-033 While rst_n is low: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, rdata=0, busy=0, sram_cen=1, sram_gwe=1, sram_addr=0, sram_in=0, state ARB, sweep counter 0, pointer=B (so A wins the first tie).
REQ-034 Reset asserted mid-operation SHALL abort a clear sweep and discard in-flight reads (no later rvalid).

Verification
REQ-035 After reset, assert a_req and b_req as reads at the same time, held continuously, in round-robin mode -> grants alternate A, B, A, B; each rvalid is a single pulse 2 cycles after its acceptance.
REQ-036 B writes 0x5A to address 0x3F; A then reads 0x3F -> sram_gwe=0 for one cycle with sram_addr=0x3F and sram_in=0x5A; later a_rdata=0x5A with a_rvalid pulse; b_rvalid stays 0.
REQ-037 Set prio_mode=1 and hold both requests for 5 cycles -> a_gnt high all 5 cycles; b_gnt never high.
REQ-038 Pulse clr_start while a_req is high -> no gnt that cycle; busy high for exactly 64 cycles; sram_addr sweeps 0x00..0x3F with sram_gwe=0 and sram_in=0; a_gnt follows after busy falls.
REQ-039 A read is accepted and rst_n is pulsed low at the next edge -> all outputs reset immediately; no rvalid appears afterwards.
REQ-040 Pulse clr_start again during CLEAR -> the sweep is not restarted; total busy duration is still 64 cycles.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two identical request/grant/read-return
// channels, A and B. The arbiter uses the slave view; requesters use the master view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) ();
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester single-port SRAM arbiter with round-robin / fixed-priority grant,
// registered SRAM strobes, a two-stage read-return pipeline and a full-memory clear sweep.
module sram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  sram_arbiter_if.slave     bus,
  input  logic              prio_mode,
  input  logic              clr_start,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_in,
  input  logic [DATA_W-1:0] sram_out,
  output logic              sram_gwe,
  output logic              sram_cen
);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_q,     state_d;
  logic              last_b_q,    last_b_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_in_q,   sram_in_d;
  logic              sram_cen_q,  sram_cen_d;
  logic              sram_gwe_q,  sram_gwe_d;

  logic              a_vld_p0_q,  a_vld_p0_d;
  logic              b_vld_p0_q,  b_vld_p0_d;
  logic              a_vld_p1_q,  a_vld_p1_d;
  logic              b_vld_p1_q,  b_vld_p1_d;
  logic              a_vld_p2_q,  a_vld_p2_d;
  logic              b_vld_p2_q,  b_vld_p2_d;
  logic [DATA_W-1:0] a_rdata_p2_q, a_rdata_p2_d;
  logic [DATA_W-1:0] b_rdata_p2_q, b_rdata_p2_d;

  logic a_gnt;
  logic b_gnt;
  logic a_acc;
  logic b_acc;

  // Grant: clr_start wins over both requesters; last_b_q=1 means B had the previous grant.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n && (state_q == ST_ARB) && !clr_start) begin
      if (prio_mode) begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req & ~bus.a_req;
      end else if (bus.a_req && bus.b_req) begin
        a_gnt = last_b_q;
        b_gnt = ~last_b_q;
      end else begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req;
      end
    end
  end

  assign a_acc = a_gnt & bus.a_req;
  assign b_acc = b_gnt & bus.b_req;

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    sram_in_d   = sram_in_q;
    sram_cen_d  = 1'b1;
    sram_gwe_d  = 1'b1;

    unique case (state_q)
      ST_ARB: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (a_acc) begin
          sram_addr_d = bus.a_addr;
          sram_in_d   = bus.a_wdata;
          sram_cen_d  = 1'b0;
          sram_gwe_d  = ~bus.a_we;
          last_b_d    = 1'b0;
        end else if (b_acc) begin
          sram_addr_d = bus.b_addr;
          sram_in_d   = bus.b_wdata;
          sram_cen_d  = 1'b0;
          sram_gwe_d  = ~bus.b_we;
          last_b_d    = 1'b1;
        end
      end
      ST_CLEAR: begin
        sram_addr_d = cnt_q;
        sram_in_d   = '0;
        sram_cen_d  = 1'b0;
        sram_gwe_d  = 1'b0;
        cnt_d       = cnt_q + ADDR_W'(1);
        // The edge that issues the top address is also the edge that leaves CLEAR.
        if (cnt_q == '1) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Read return: p0 = strobes on the SRAM pins, p1 = SRAM data out, p2 = rdata/rvalid.
  always_comb begin
    a_vld_p0_d   = a_acc & ~bus.a_we;
    b_vld_p0_d   = b_acc & ~bus.b_we;
    a_vld_p1_d   = a_vld_p0_q;
    b_vld_p1_d   = b_vld_p0_q;
    a_vld_p2_d   = a_vld_p1_q;
    b_vld_p2_d   = b_vld_p1_q;
    a_rdata_p2_d = a_vld_p1_q ? sram_out : a_rdata_p2_q;
    b_rdata_p2_d = b_vld_p1_q ? sram_out : b_rdata_p2_q;
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      last_b_q     <= 1'b1;
      cnt_q        <= '0;
      sram_addr_q  <= '0;
      sram_in_q    <= '0;
      sram_cen_q   <= 1'b1;
      sram_gwe_q   <= 1'b1;
      a_vld_p0_q   <= 1'b0;
      b_vld_p0_q   <= 1'b0;
      a_vld_p1_q   <= 1'b0;
      b_vld_p1_q   <= 1'b0;
      a_vld_p2_q   <= 1'b0;
      b_vld_p2_q   <= 1'b0;
      a_rdata_p2_q <= '0;
      b_rdata_p2_q <= '0;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      cnt_q        <= cnt_d;
      sram_addr_q  <= sram_addr_d;
      sram_in_q    <= sram_in_d;
      sram_cen_q   <= sram_cen_d;
      sram_gwe_q   <= sram_gwe_d;
      a_vld_p0_q   <= a_vld_p0_d;
      b_vld_p0_q   <= b_vld_p0_d;
      a_vld_p1_q   <= a_vld_p1_d;
      b_vld_p1_q   <= b_vld_p1_d;
      a_vld_p2_q   <= a_vld_p2_d;
      b_vld_p2_q   <= b_vld_p2_d;
      a_rdata_p2_q <= a_rdata_p2_d;
      b_rdata_p2_q <= b_rdata_p2_d;
    end
  end

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_vld_p2_q;
  assign bus.b_rvalid = b_vld_p2_q;
  assign bus.a_rdata  = a_rdata_p2_q;
  assign bus.b_rdata  = b_rdata_p2_q;

  assign busy      = (state_q == ST_CLEAR);
  assign sram_addr = sram_addr_q;
  assign sram_in   = sram_in_q;
  assign sram_cen  = sram_cen_q;
  assign sram_gwe  = sram_gwe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, a cycle-level scoreboard model checked on
// every falling edge, and directed scenarios with hand-computed expectations.
module tb_sram_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          prio_mode;
  logic          clr_start;
  logic          busy;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_in;
  logic [DW-1:0] sram_out = '0;
  logic          sram_gwe;
  logic          sram_cen;

  int checks = 0;
  int errors = 0;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .wb_clk_i  (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .prio_mode (prio_mode),
    .clr_start (clr_start),
    .busy      (busy),
    .sram_addr (sram_addr),
    .sram_in   (sram_in),
    .sram_out  (sram_out),
    .sram_gwe  (sram_gwe),
    .sram_cen  (sram_cen)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(int a);
    return DW'(a * 7 + 3);
  endfunction

  // Synchronous SRAM: unwritten locations read back pat(addr).
  logic [DW-1:0] mem [64];
  bit            wr  [64];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwe) begin
        mem[sram_addr] <= sram_in;
        wr[sram_addr]  <= 1'b1;
      end else begin
        sram_out <= wr[sram_addr] ? mem[sram_addr] : pat(int'(sram_addr));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Scoreboard model state
  int            ncyc = 0;
  bit            m_last_b, m_clear;
  int            m_sweep;
  logic [DW-1:0] m_mem [64];
  bit            m_wr  [64];
  logic [AW-1:0] m_addr, n_addr;
  logic [DW-1:0] m_in, n_in;
  logic          m_cen, n_cen, m_gwe, n_gwe;
  logic [DW-1:0] m_rd_a, m_rd_b;
  int            qa_t[$], qb_t[$];
  logic [DW-1:0] qa_d[$], qb_d[$];
  int            busy_cnt = 0;
  int            zw_cnt = 0;
  logic [AW-1:0] zw_last = '0;
  int            rv_cnt = 0;

  function automatic logic [DW-1:0] mrd(int a);
    return m_wr[a] ? m_mem[a] : pat(a);
  endfunction

  always @(negedge clk) begin
    bit ea, eb, rva, rvb;
    ncyc++;
    if (!rst_n) begin
      m_last_b = 1'b1; m_clear = 1'b0; m_sweep = 0;
      m_addr = '0; m_in = '0; m_cen = 1'b1; m_gwe = 1'b1;
      n_addr = '0; n_in = '0; n_cen = 1'b1; n_gwe = 1'b1;
      m_rd_a = '0; m_rd_b = '0;
      qa_t.delete(); qa_d.delete(); qb_t.delete(); qb_d.delete();
      chk("rst_a_gnt", 32'(bus.a_gnt), 32'(0));
      chk("rst_b_gnt", 32'(bus.b_gnt), 32'(0));
      chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'(0));
      chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'(0));
      chk("rst_a_rdata", 32'(bus.a_rdata), 32'(0));
      chk("rst_b_rdata", 32'(bus.b_rdata), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_cen", 32'(sram_cen), 32'(1));
      chk("rst_gwe", 32'(sram_gwe), 32'(1));
      chk("rst_addr", 32'(sram_addr), 32'(0));
      chk("rst_in", 32'(sram_in), 32'(0));
    end else begin
      m_addr = n_addr; m_in = n_in; m_cen = n_cen; m_gwe = n_gwe;
      rva = (qa_t.size() > 0) && (qa_t[0] == ncyc);
      rvb = (qb_t.size() > 0) && (qb_t[0] == ncyc);
      if (rva) begin m_rd_a = qa_d[0]; void'(qa_t.pop_front()); void'(qa_d.pop_front()); end
      if (rvb) begin m_rd_b = qb_d[0]; void'(qb_t.pop_front()); void'(qb_d.pop_front()); end
      ea = 1'b0; eb = 1'b0;
      if (!m_clear && !clr_start) begin
        if (prio_mode) begin ea = bus.a_req; eb = bus.b_req && !bus.a_req; end
        else if (bus.a_req && bus.b_req) begin ea = m_last_b; eb = !m_last_b; end
        else begin ea = bus.a_req; eb = bus.b_req; end
      end
      chk("m_a_gnt", 32'(bus.a_gnt), 32'(ea));
      chk("m_b_gnt", 32'(bus.b_gnt), 32'(eb));
      chk("m_busy", 32'(busy), 32'(m_clear));
      chk("m_cen", 32'(sram_cen), 32'(m_cen));
      chk("m_gwe", 32'(sram_gwe), 32'(m_gwe));
      chk("m_addr", 32'(sram_addr), 32'(m_addr));
      chk("m_in", 32'(sram_in), 32'(m_in));
      chk("m_a_rvalid", 32'(bus.a_rvalid), 32'(rva));
      chk("m_b_rvalid", 32'(bus.b_rvalid), 32'(rvb));
      chk("m_a_rdata", 32'(bus.a_rdata), 32'(m_rd_a));
      chk("m_b_rdata", 32'(bus.b_rdata), 32'(m_rd_b));
      // What the coming rising edge must do
      n_cen = 1'b1; n_gwe = 1'b1;
      if (m_clear) begin
        n_addr = AW'(m_sweep); n_in = '0; n_cen = 1'b0; n_gwe = 1'b0;
        m_mem[m_sweep] = '0; m_wr[m_sweep] = 1'b1;
        m_sweep++;
        if (m_sweep == 64) m_clear = 1'b0;
      end else if (clr_start) begin
        m_clear = 1'b1; m_sweep = 0;
      end else if (ea) begin
        n_addr = bus.a_addr; n_in = bus.a_wdata; n_cen = 1'b0; n_gwe = !bus.a_we;
        if (bus.a_we) begin m_mem[bus.a_addr] = bus.a_wdata; m_wr[bus.a_addr] = 1'b1; end
        else begin qa_t.push_back(ncyc + 3); qa_d.push_back(mrd(int'(bus.a_addr))); end
        m_last_b = 1'b0;
      end else if (eb) begin
        n_addr = bus.b_addr; n_in = bus.b_wdata; n_cen = 1'b0; n_gwe = !bus.b_we;
        if (bus.b_we) begin m_mem[bus.b_addr] = bus.b_wdata; m_wr[bus.b_addr] = 1'b1; end
        else begin qb_t.push_back(ncyc + 3); qb_d.push_back(mrd(int'(bus.b_addr))); end
        m_last_b = 1'b1;
      end
    end
    if (busy) busy_cnt++;
    if (!sram_cen && !sram_gwe && (sram_in == '0)) begin zw_cnt++; zw_last = sram_addr; end
    if (bus.a_rvalid || bus.b_rvalid) rv_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cyc(1);
    end
    chk(name, 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, b0, z0, r0;
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    rst_n = 1'b0; prio_mode = 1'b0; clr_start = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 6'h05; bus.a_wdata = 8'h00;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 6'h09; bus.b_wdata = 8'h00;
    cyc(3);

    // Round-robin tie with both reads held: A, B, A, B
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_grant", 32'({bus.b_gnt, bus.a_gnt}), 32'(rr_exp[i]));
      cyc(1);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    cyc(3);
    chk("rr_a_rdata", 32'(bus.a_rdata), 32'h26);
    chk("rr_b_rdata", 32'(bus.b_rdata), 32'h42);

    // B writes 0x5A to 0x3F, then A reads it back
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 6'h3F; bus.b_wdata = 8'h5A;
    cyc(1);
    chk("wr_gwe", 32'(sram_gwe), 32'(0));
    chk("wr_addr", 32'(sram_addr), 32'h3F);
    chk("wr_in", 32'(sram_in), 32'h5A);
    bus.b_req = 1'b0; bus.b_we = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 6'h3F;
    cyc(1);
    bus.a_req = 1'b0;
    cyc(2);
    chk("rd_a_rvalid", 32'(bus.a_rvalid), 32'(1));
    chk("rd_a_rdata", 32'(bus.a_rdata), 32'h5A);
    chk("rd_b_rvalid", 32'(bus.b_rvalid), 32'(0));
    cyc(1);
    chk("rd_a_rvalid_pulse", 32'(bus.a_rvalid), 32'(0));

    // Fixed priority: A wins all five cycles
    prio_mode = 1'b1; bus.a_req = 1'b1; bus.b_req = 1'b1;
    na = 0; nb = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.a_gnt) na++;
      if (bus.b_gnt) nb++;
      cyc(1);
    end
    chk("prio_a_cnt", 32'(na), 32'(5));
    chk("prio_b_cnt", 32'(nb), 32'(0));
    bus.a_req = 1'b0; bus.b_req = 1'b0; prio_mode = 1'b0;
    cyc(4);

    // Accepted read, then reset: outputs clear at once and the read never returns
    bus.a_req = 1'b1; bus.a_addr = 6'h07;
    cyc(1);
    bus.a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_cen", 32'(sram_cen), 32'(1));
    chk("arst_addr", 32'(sram_addr), 32'(0));
    chk("arst_a_rdata", 32'(bus.a_rdata), 32'(0));
    r0 = rv_cnt;
    cyc(1);
    rst_n = 1'b1;
    cyc(5);
    chk("arst_no_rvalid", 32'(rv_cnt - r0), 32'(0));

    // Read in flight, then clear with A still requesting
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 6'h10;
    cyc(1);
    clr_start = 1'b1;
    #1;
    chk("clr_no_gnt", 32'({bus.b_gnt, bus.a_gnt}), 32'(0));
    b0 = busy_cnt; z0 = zw_cnt;
    cyc(1);
    clr_start = 1'b0;
    chk("clr_busy", 32'(busy), 32'(1));
    wait_idle("clr_timeout");
    chk("clr_pre_read", 32'(bus.a_rdata), 32'h73);
    #1;
    chk("clr_gnt_after", 32'(bus.a_gnt), 32'(1));
    cyc(1);
    bus.a_req = 1'b0;
    chk("clr_busy_len", 32'(busy_cnt - b0), 32'(64));
    chk("clr_zero_writes", 32'(zw_cnt - z0), 32'(64));
    chk("clr_last_addr", 32'(zw_last), 32'h3F);
    cyc(3);
    chk("clr_post_read", 32'(bus.a_rdata), 32'(0));

    // Second clr_start during CLEAR does not restart the sweep
    b0 = busy_cnt;
    clr_start = 1'b1;
    cyc(1);
    clr_start = 1'b0;
    cyc(10);
    clr_start = 1'b1;
    cyc(1);
    clr_start = 1'b0;
    wait_idle("clr2_timeout");
    chk("clr2_busy_len", 32'(busy_cnt - b0), 32'(64));
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
